// File: rtl/hazard_scoreboard_if.sv
// ID-side request and EX-side forwarding/stall response of the hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int NSRC  = 2,
    parameter int SELW  = 2,
    parameter int CNT_W = 16
);
    logic                 id_valid;
    logic [NSRC*5-1:0]    id_rs;
    logic [NSRC-1:0]      id_rs_used;
    logic [4:0]           id_rd;
    logic                 id_we;
    logic                 id_is_load;
    logic                 id_is_multi;
    logic                 multi_done;
    logic                 flush;
    logic                 stall;
    logic [NSRC*SELW-1:0] ex_fwd_sel;
    logic                 ex_valid;
    logic [CNT_W-1:0]     stall_cnt;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_we, id_is_load, id_is_multi,
               multi_done, flush,
        input  stall, ex_fwd_sel, ex_valid, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_we, id_is_load, id_is_multi,
               multi_done, flush,
        output stall, ex_fwd_sel, ex_valid, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shadow pipeline of in-flight register writers: per-operand forwarding selects,
// load-use / multi-cycle stalls, flush bubbling and a saturating stall counter.
module hazard_scoreboard #(
    parameter int NSRC     = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SELW     = (DEPTH > 2) ? $clog2(DEPTH) : 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave bus
);
    localparam int              SW1     = SELW + 1;
    localparam logic [SELW:0]   DEPTH_W = SW1'(DEPTH);
    localparam logic [SELW-1:0] LOAD_W  = SELW'(LOAD_LAT);

    logic [DEPTH-1:0]           valid_r;
    logic [DEPTH-1:0]           we_r;
    logic [DEPTH-1:0]           load_r;
    logic [DEPTH-1:0][4:0]      rd_r;
    logic                       multi0_r;
    logic [NSRC-1:0][4:0]       ex_rs_r;
    logic [NSRC-1:0]            ex_used_r;
    logic [NSRC-1:0][SELW-1:0]  sel_r;
    logic [CNT_W-1:0]           cnt_r;

    logic [DEPTH-1:0]           writer_s;
    logic [DEPTH-1:0]           ex_mask_s;
    logic [NSRC-1:0]            id_used_s;
    logic [NSRC-1:0][SELW-1:0]  id_cand_s;
    logic [NSRC-1:0][SELW-1:0]  ex_cand_s;
    logic                       load_hz_s;
    logic                       multi_hz_s;
    logic                       stall_s;

    // Youngest (lowest-index) slot in wr_mask writing rs, returned as {hit, slot}.
    function automatic logic [SELW:0] find_writer(input logic [4:0] rs,
                                                  input logic [DEPTH-1:0] wr_mask,
                                                  input logic [DEPTH-1:0][4:0] rd);
        logic [SELW:0] res;
        res = {SW1{1'b0}};
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (wr_mask[k] && (rd[k] == rs)) begin
                res = {1'b1, SELW'(k)};
            end
        end
        return res;
    endfunction

    // A writer found in slot k will sit in slot k+1 once the reader is in EX.
    function automatic logic [SELW-1:0] cand_of(input logic [SELW:0] m);
        logic [SELW:0] nxt;
        nxt = {1'b0, m[SELW-1:0]} + {{SELW{1'b0}}, 1'b1};
        if (m[SELW] && (nxt < DEPTH_W)) begin
            return nxt[SELW-1:0];
        end else begin
            return {SELW{1'b0}};
        end
    endfunction

    // Writer mask, ID-side and held-EX lookups, hazard decode.
    always_comb begin
        logic [SELW:0] m;
        logic [4:0]    rs;
        m         = {SW1{1'b0}};
        rs        = 5'd0;
        load_hz_s = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            writer_s[k] = valid_r[k] & we_r[k] & (rd_r[k] != 5'd0);
        end
        // The held EX instruction must not match its own slot.
        ex_mask_s = {writer_s[DEPTH-1:1], 1'b0};
        for (int s = 0; s < NSRC; s++) begin
            rs           = bus.id_rs[5*s +: 5];
            id_used_s[s] = bus.id_valid & bus.id_rs_used[s] & (rs != 5'd0);
            m            = id_used_s[s] ? find_writer(rs, writer_s, rd_r) : {SW1{1'b0}};
            id_cand_s[s] = cand_of(m);
            load_hz_s    = load_hz_s | (m[SELW] & load_r[m[SELW-1:0]] & (m[SELW-1:0] < LOAD_W));
            m            = ex_used_r[s] ? find_writer(ex_rs_r[s], ex_mask_s, rd_r) : {SW1{1'b0}};
            ex_cand_s[s] = cand_of(m);
        end
        multi_hz_s = valid_r[0] & multi0_r & ~bus.multi_done;
        stall_s    = ~bus.flush & (load_hz_s | multi_hz_s);
    end

    // Shadow pipeline advance, EX select register and stall counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_r   <= {DEPTH{1'b0}};
            we_r      <= {DEPTH{1'b0}};
            load_r    <= {DEPTH{1'b0}};
            rd_r      <= {(DEPTH*5){1'b0}};
            multi0_r  <= 1'b0;
            ex_rs_r   <= {(NSRC*5){1'b0}};
            ex_used_r <= {NSRC{1'b0}};
            sel_r     <= {(NSRC*SELW){1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            if (stall_s && (cnt_r != {CNT_W{1'b1}})) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            for (int k = DEPTH - 1; k >= 2; k--) begin
                valid_r[k] <= valid_r[k-1];
                we_r[k]    <= we_r[k-1];
                load_r[k]  <= load_r[k-1];
                rd_r[k]    <= rd_r[k-1];
            end
            if (bus.flush) begin
                valid_r[1:0] <= 2'b00;
                multi0_r     <= 1'b0;
                ex_used_r    <= {NSRC{1'b0}};
                sel_r        <= {(NSRC*SELW){1'b0}};
            end else if (multi_hz_s) begin
                valid_r[1] <= 1'b0;
                sel_r      <= ex_cand_s;
            end else begin
                valid_r[1] <= valid_r[0];
                we_r[1]    <= we_r[0];
                load_r[1]  <= load_r[0];
                rd_r[1]    <= rd_r[0];
                if (load_hz_s) begin
                    valid_r[0] <= 1'b0;
                    multi0_r   <= 1'b0;
                    ex_used_r  <= {NSRC{1'b0}};
                    sel_r      <= {(NSRC*SELW){1'b0}};
                end else begin
                    valid_r[0] <= bus.id_valid;
                    we_r[0]    <= bus.id_we;
                    load_r[0]  <= bus.id_is_load;
                    rd_r[0]    <= bus.id_rd;
                    multi0_r   <= bus.id_is_multi;
                    ex_rs_r    <= bus.id_rs;
                    ex_used_r  <= id_used_s;
                    sel_r      <= id_cand_s;
                end
            end
        end
    end

    assign bus.stall      = stall_s;
    assign bus.ex_fwd_sel = sel_r;
    assign bus.ex_valid   = valid_r[0];
    assign bus.stall_cnt  = cnt_r;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed vector bench: DEPTH=3 and DEPTH=4 scoreboards driven with identical ID streams.
module tb_hazard_scoreboard;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct {
        logic        rstn;
        logic        v;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic [1:0]  used;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
        logic        mul;
        logic        md;
        logic        fl;
        logic        e_stall;
        logic [3:0]  e_sel3;
        logic [3:0]  e_sel4;
        logic        e_exv;
        logic [15:0] e_cnt;
    } vec_t;

    logic clk;
    logic rst;
    vec_t vecs[$];
    vec_t nop0;
    int   n_cmp = 0;
    int   n_bad = 0;

    hazard_scoreboard_if #(.NSRC(2), .SELW(2), .CNT_W(16)) b3 ();
    hazard_scoreboard_if #(.NSRC(2), .SELW(2), .CNT_W(16)) b4 ();

    assign b4.id_valid    = b3.id_valid;
    assign b4.id_rs       = b3.id_rs;
    assign b4.id_rs_used  = b3.id_rs_used;
    assign b4.id_rd       = b3.id_rd;
    assign b4.id_we       = b3.id_we;
    assign b4.id_is_load  = b3.id_is_load;
    assign b4.id_is_multi = b3.id_is_multi;
    assign b4.multi_done  = b3.multi_done;
    assign b4.flush       = b3.flush;

    hazard_scoreboard #(.NSRC(2), .DEPTH(3), .LOAD_LAT(1), .SELW(2), .CNT_W(16)) u_dut3 (
        .clk(clk), .rst(rst), .bus(b3)
    );
    hazard_scoreboard #(.NSRC(2), .DEPTH(4), .LOAD_LAT(1), .SELW(2), .CNT_W(16)) u_dut4 (
        .clk(clk), .rst(rst), .bus(b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rstn, input logic v, input logic [4:0] rs0,
                                input logic [4:0] rs1, input logic [1:0] used, input logic [4:0] rd,
                                input logic we, input logic ld, input logic mul, input logic md,
                                input logic fl, input logic es, input logic [3:0] s3,
                                input logic [3:0] s4, input logic ev, input logic [15:0] ec);
        vec_t r;
        r.rstn = rstn; r.v = v; r.rs0 = rs0; r.rs1 = rs1; r.used = used; r.rd = rd;
        r.we = we; r.ld = ld; r.mul = mul; r.md = md; r.fl = fl;
        r.e_stall = es; r.e_sel3 = s3; r.e_sel4 = s4; r.e_exv = ev; r.e_cnt = ec;
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst            = v.rstn;
        b3.id_valid    = v.v;
        b3.id_rs       = {v.rs1, v.rs0};
        b3.id_rs_used  = v.used;
        b3.id_rd       = v.rd;
        b3.id_we       = v.we;
        b3.id_is_load  = v.ld;
        b3.id_is_multi = v.mul;
        b3.multi_done  = v.md;
        b3.flush       = v.fl;
    endtask

    initial begin
        // rstn v rs0 rs1 used rd we ld mul md fl | stall sel3 sel4 exv cnt
        vecs.push_back(mk(H,H,5'd1,5'd2,2'b11,5'd5,H,L,L,L,L, L,4'h0,4'h0,H,16'd0));  // add x5
        vecs.push_back(mk(H,H,5'd5,5'd5,2'b11,5'd6,H,L,L,L,L, L,4'h5,4'h5,H,16'd0));  // sub x6,x5,x5
        vecs.push_back(mk(H,L,5'd0,5'd0,2'b00,5'd0,L,L,L,L,L, L,4'h0,4'h0,L,16'd0));  // nop
        vecs.push_back(mk(H,H,5'd1,5'd0,2'b01,5'd7,H,H,L,L,L, L,4'h0,4'h0,H,16'd0));  // lw x7
        vecs.push_back(mk(H,H,5'd7,5'd0,2'b11,5'd8,H,L,L,L,L, H,4'h0,4'h0,L,16'd1));  // add x8,x7,x0 stalls
        vecs.push_back(mk(H,H,5'd7,5'd0,2'b11,5'd8,H,L,L,L,L, L,4'h2,4'h2,H,16'd1));  // released
        vecs.push_back(mk(H,H,5'd1,5'd2,2'b11,5'd3,H,L,L,L,L, L,4'h0,4'h0,H,16'd1));  // add x3
        vecs.push_back(mk(H,L,5'd0,5'd0,2'b00,5'd0,L,L,L,L,L, L,4'h0,4'h0,L,16'd1));
        vecs.push_back(mk(H,L,5'd0,5'd0,2'b00,5'd0,L,L,L,L,L, L,4'h0,4'h0,L,16'd1));
        vecs.push_back(mk(H,H,5'd3,5'd3,2'b11,5'd4,H,L,L,L,L, L,4'h0,4'hF,H,16'd1));  // or x4,x3,x3
        vecs.push_back(mk(H,H,5'd1,5'd2,2'b11,5'd9,H,L,H,L,L, L,4'h0,4'h0,H,16'd1));  // div x9
        vecs.push_back(mk(H,H,5'd9,5'd1,2'b11,5'd10,H,L,L,L,L, H,4'h0,4'h0,H,16'd2)); // add x10,x9,x1
        vecs.push_back(mk(H,H,5'd9,5'd1,2'b11,5'd10,H,L,L,L,L, H,4'h0,4'h0,H,16'd3));
        vecs.push_back(mk(H,H,5'd9,5'd1,2'b11,5'd10,H,L,L,L,L, H,4'h0,4'h0,H,16'd4));
        vecs.push_back(mk(H,H,5'd9,5'd1,2'b11,5'd10,H,L,L,L,L, H,4'h0,4'h0,H,16'd5));
        vecs.push_back(mk(H,H,5'd9,5'd1,2'b11,5'd10,H,L,L,H,L, L,4'h1,4'h1,H,16'd5)); // multi_done
        vecs.push_back(mk(H,H,5'd1,5'd0,2'b01,5'd7,H,H,L,L,L, L,4'h0,4'h0,H,16'd5));  // lw x7
        vecs.push_back(mk(H,H,5'd7,5'd0,2'b11,5'd8,H,L,L,L,H, L,4'h0,4'h0,L,16'd5));  // dependent + flush
        vecs.push_back(mk(H,H,5'd10,5'd7,2'b11,5'd11,H,L,L,L,L, L,4'h0,4'h3,H,16'd5)); // lw killed
        vecs.push_back(mk(H,H,5'd1,5'd2,2'b11,5'd9,H,L,H,L,L, L,4'h0,4'h0,H,16'd5));  // div x9
        vecs.push_back(mk(H,H,5'd9,5'd1,2'b11,5'd10,H,L,L,L,L, H,4'h0,4'h0,H,16'd6));
        vecs.push_back(mk(L,H,5'd9,5'd1,2'b11,5'd10,H,L,L,L,L, H,4'h0,4'h0,L,16'd0)); // reset mid-multi
        vecs.push_back(mk(H,L,5'd0,5'd0,2'b00,5'd0,L,L,L,L,L, L,4'h0,4'h0,L,16'd0));
        vecs.push_back(mk(H,H,5'd1,5'd2,2'b11,5'd9,H,L,H,L,L, L,4'h0,4'h0,H,16'd0));  // div x9
        vecs.push_back(mk(H,H,5'd9,5'd1,2'b11,5'd10,H,L,L,L,H, L,4'h0,4'h0,L,16'd0)); // flush beats multi
        vecs.push_back(mk(H,L,5'd0,5'd0,2'b00,5'd0,L,L,L,L,L, L,4'h0,4'h0,L,16'd0));  // multi cancelled
        vecs.push_back(mk(H,H,5'd1,5'd2,2'b11,5'd12,H,L,L,L,L, L,4'h0,4'h0,H,16'd0)); // add x12
        vecs.push_back(mk(H,H,5'd12,5'd1,2'b11,5'd13,H,L,H,L,L, L,4'h1,4'h1,H,16'd0)); // div x13,x12,x1
        vecs.push_back(mk(H,L,5'd0,5'd0,2'b00,5'd0,L,L,L,L,L, H,4'h2,4'h2,H,16'd1));  // held: reselect
        vecs.push_back(mk(H,L,5'd0,5'd0,2'b00,5'd0,L,L,L,L,L, H,4'h0,4'h3,H,16'd2));
        vecs.push_back(mk(H,L,5'd0,5'd0,2'b00,5'd0,L,L,L,L,L, H,4'h0,4'h0,H,16'd3));
        vecs.push_back(mk(H,L,5'd0,5'd0,2'b00,5'd0,L,L,L,H,L, L,4'h0,4'h0,L,16'd3));

        nop0 = mk(H,L,5'd0,5'd0,2'b00,5'd0,L,L,L,L,L, L,4'h0,4'h0,L,16'd0);
        drive(mk(L,L,5'd0,5'd0,2'b00,5'd0,L,L,L,L,L, L,4'h0,4'h0,L,16'd0));
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", {15'd0, b3.stall}, 16'd0);
        check("rst_sel3", {12'd0, b3.ex_fwd_sel}, 16'd0);
        check("rst_sel4", {12'd0, b4.ex_fwd_sel}, 16'd0);
        check("rst_exv", {15'd0, b3.ex_valid}, 16'd0);
        check("rst_cnt", b3.stall_cnt, 16'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d_stall3", i), {15'd0, b3.stall}, {15'd0, vecs[i].e_stall});
            check($sformatf("v%0d_stall4", i), {15'd0, b4.stall}, {15'd0, vecs[i].e_stall});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_sel3", i), {12'd0, b3.ex_fwd_sel}, {12'd0, vecs[i].e_sel3});
            check($sformatf("v%0d_sel4", i), {12'd0, b4.ex_fwd_sel}, {12'd0, vecs[i].e_sel4});
            check($sformatf("v%0d_exv", i), {15'd0, b3.ex_valid}, {15'd0, vecs[i].e_exv});
            check($sformatf("v%0d_cnt", i), b3.stall_cnt, vecs[i].e_cnt);
        end

        // Saturation: counter starts at 3, a never-finishing div stalls every cycle.
        @(negedge clk);
        drive(mk(H,H,5'd1,5'd2,2'b11,5'd9,H,L,H,L,L, L,4'h0,4'h0,H,16'd0));
        @(posedge clk);
        for (int i = 0; i < 65531; i++) begin
            @(negedge clk);
            drive(nop0);
            @(posedge clk);
        end
        #1;
        check("sat_fffe", b3.stall_cnt, 16'hFFFE);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(nop0);
            @(posedge clk);
        end
        #1;
        check("sat_hold", b3.stall_cnt, 16'hFFFF);
        check("sat_stall", {15'd0, b3.stall}, 16'd1);
        @(negedge clk);
        drive(mk(H,L,5'd0,5'd0,2'b00,5'd0,L,L,L,H,H, L,4'h0,4'h0,L,16'd0));
        #1;
        check("sat_flush_stall", {15'd0, b3.stall}, 16'd0);
        @(posedge clk);
        #1;
        check("sat_flush_cnt", b3.stall_cnt, 16'hFFFF);
        check("sat_flush_exv", {15'd0, b3.ex_valid}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
